mmul_parallel_kernel_sched: RTL and testbench

- Sequences the HLS matrix-multiply kernel through its ap_start/ap_ready/ap_done/ap_idle handshake for a programmed number of iterations.
- Sits inside the HWPE engine between the register-file/controller FSM and the kernel adapter.
- Monitors the output stream handshake so the job finishes only when every expected output beat has left the kernel.
- Reports a single completion pulse, progress counters and a sticky error flag.

---
 rtl/mmul_parallel_package.sv | 17 +
 rtl/mmul_parallel_evt_counter.sv | 47 ++++
 rtl/mmul_parallel_kernel_sched.sv | 160 ++++++++++++++++
 tb/tb_mmul_parallel_kernel_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmul_parallel_package.sv
// Shared types and default widths for the matrix-multiply kernel scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mmul_parallel_package;

    localparam int unsigned ITER_W_DEF = 16;
    localparam int unsigned BEAT_W_DEF = 16;
    localparam int unsigned WDOG_W_DEF = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/mmul_parallel_evt_counter.sv
// Clearable, loadable up-counter with an at-limit flag (cnt_o == lim_i).
// Latency: count updates one cycle after clr_i/ld_i/inc_i; at_lim_o is combinational on the count.
// Backpressure: none; every inc_i cycle is counted, wrapping at all-ones.
// Ports: clk_i/rst_ni clock and async active-low reset; clr_i sync zero (highest priority);
//        ld_i/ld_val_i sync load; inc_i increment; lim_i compare value; cnt_o count; at_lim_o flag.
module mmul_parallel_evt_counter
    import mmul_parallel_package::*;
#(
    parameter int unsigned W = ITER_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] lim_i,
    output logic [W-1:0] cnt_o,
    output logic         at_lim_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign at_lim_o = (cnt_q == lim_i);

endmodule

// File: rtl/mmul_parallel_kernel_sched.sv
// Drives the HLS kernel ap_start/ap_ready/ap_done handshake for n_iter invocations and waits for all output beats.
// Latency: start_i to first ap_start_o = 1 cycle; last done/beat event to done_o = 1 cycle.
// Backpressure: honours ap_ready_i for issue; out stream is monitored only, never stalled.
// Ports: clk_i/rst_ni, clear_i soft clear, start_i/n_iter_i/beats_i job request, ap_* kernel control,
//        out_valid_i/out_ready_i stream monitor, busy_o/done_o/issued_o/finished_o/err_o status.
module mmul_parallel_kernel_sched
    import mmul_parallel_package::*;
#(
    parameter int unsigned ITER_W = ITER_W_DEF,
    parameter int unsigned BEAT_W = BEAT_W_DEF,
    parameter int unsigned WDOG_W = WDOG_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [ITER_W-1:0] n_iter_i,
    input  logic [BEAT_W-1:0] beats_i,
    output logic              ap_start_o,
    input  logic              ap_ready_i,
    input  logic              ap_done_i,
    input  logic              ap_idle_i,
    input  logic              out_valid_i,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ITER_W-1:0] issued_o,
    output logic [ITER_W-1:0] finished_o,
    output logic              err_o
);

    localparam int unsigned TOT_W = ITER_W + BEAT_W;

    sched_state_e      state_q;
    logic [ITER_W-1:0] n_iter_q;
    logic [TOT_W-1:0]  total_q;
    logic              ap_start_q, busy_q, done_q, err_q;

    logic              active, running, accept, cnt_clr;
    logic              hs, beat, evt;
    logic [TOT_W-1:0]  total_d;
    logic [ITER_W-1:0] iss_cnt, fin_cnt;
    logic [TOT_W-1:0]  beat_cnt;
    logic [WDOG_W-1:0] wdog_cnt_unused;
    logic              iss_last, fin_full, beat_full, wdog_at;
    logic              fin_reach, beat_reach, wdog_exp, ev_err;

    assign active  = (state_q != IDLE);
    assign running = (state_q == ISSUE) || (state_q == WAIT);
    assign accept  = (state_q == IDLE) && start_i && !clear_i;
    assign cnt_clr = clear_i || accept;
    assign hs      = ap_start_q && ap_ready_i;
    assign beat    = out_valid_i && out_ready_i;
    assign evt     = ap_ready_i || ap_done_i || beat;
    assign total_d = TOT_W'(n_iter_i) * TOT_W'(beats_i);

    mmul_parallel_evt_counter #(.W(ITER_W)) u_issued (
        .clk_i, .rst_ni, .clr_i(cnt_clr), .ld_i(1'b0), .ld_val_i('0),
        .inc_i(active && hs), .lim_i(n_iter_q - ITER_W'(1)),
        .cnt_o(iss_cnt), .at_lim_o(iss_last)
    );

    mmul_parallel_evt_counter #(.W(ITER_W)) u_finished (
        .clk_i, .rst_ni, .clr_i(cnt_clr), .ld_i(1'b0), .ld_val_i('0),
        .inc_i(active && ap_done_i), .lim_i(n_iter_q),
        .cnt_o(fin_cnt), .at_lim_o(fin_full)
    );

    mmul_parallel_evt_counter #(.W(TOT_W)) u_beats (
        .clk_i, .rst_ni, .clr_i(cnt_clr), .ld_i(1'b0), .ld_val_i('0),
        .inc_i(active && beat), .lim_i(total_q),
        .cnt_o(beat_cnt), .at_lim_o(beat_full)
    );

    // Compared one below all-ones so expiry fires on the idle cycle that takes the count to all-ones.
    mmul_parallel_evt_counter #(.W(WDOG_W)) u_wdog (
        .clk_i, .rst_ni, .clr_i(clear_i || !running || evt), .ld_i(1'b0), .ld_val_i('0),
        .inc_i(running && !evt), .lim_i(~WDOG_W'(1)),
        .cnt_o(wdog_cnt_unused), .at_lim_o(wdog_at)
    );

    // Completion compares include this cycle's increment.
    assign fin_reach  = (active && ap_done_i) ? (fin_cnt == n_iter_q - ITER_W'(1)) : fin_full;
    assign beat_reach = (active && beat) ? (beat_cnt == total_q - TOT_W'(1)) : beat_full;
    assign wdog_exp   = wdog_at && running && !evt;
    assign ev_err     = (ap_done_i && fin_full) || (beat && beat_full) || wdog_exp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            n_iter_q   <= '0;
            total_q    <= '0;
            ap_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (clear_i) begin
            state_q    <= IDLE;
            n_iter_q   <= '0;
            total_q    <= '0;
            ap_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (active && ev_err) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        n_iter_q <= n_iter_i;
                        total_q  <= total_d;
                        if (n_iter_i != '0) begin
                            state_q    <= ISSUE;
                            ap_start_q <= 1'b1;
                            busy_q     <= 1'b1;
                            // A kernel that is not idle at job start is flagged but still driven.
                            err_q      <= !ap_idle_i;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (wdog_exp) begin
                        state_q    <= DONE;
                        ap_start_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else if (hs && iss_last) begin
                        state_q    <= WAIT;
                        ap_start_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (wdog_exp || (fin_reach && beat_reach)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ap_start_o = ap_start_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign issued_o   = iss_cnt;
    assign finished_o = fin_cnt;

endmodule

// File: tb/tb_mmul_parallel_kernel_sched.sv
// Directed bench for the kernel scheduler: job sequencing, zero-iteration jobs, coincident events,
// error stickiness, soft clear priority and watchdog expiry (second instance with a 4-bit watchdog).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_mmul_parallel_kernel_sched;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] n_iter_i = '0;
    logic [15:0] beats_i = '0;
    logic        ap_ready_i = 1'b0;
    logic        ap_done_i = 1'b0;
    logic        ap_idle_i = 1'b1;
    logic        out_valid_i = 1'b0;
    logic        out_ready_i = 1'b0;

    logic        ap_start_o, busy_o, done_o, err_o;
    logic [15:0] issued_o, finished_o;
    logic        w_ap_start, w_busy, w_done, w_err;
    logic [15:0] w_issued, w_finished;

    int n_chk = 0;
    int n_err = 0;
    int st_cnt, dn_cnt, dn_at, nbeat, last_beat, err_at;
    int hs_cyc[$];

    always #5 clk_i = ~clk_i;

    mmul_parallel_kernel_sched dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .n_iter_i(n_iter_i), .beats_i(beats_i), .ap_start_o(ap_start_o),
        .ap_ready_i(ap_ready_i), .ap_done_i(ap_done_i), .ap_idle_i(ap_idle_i),
        .out_valid_i(out_valid_i), .out_ready_i(out_ready_i), .busy_o(busy_o),
        .done_o(done_o), .issued_o(issued_o), .finished_o(finished_o), .err_o(err_o)
    );

    mmul_parallel_kernel_sched #(.WDOG_W(4)) dut_wdog (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .n_iter_i(n_iter_i), .beats_i(beats_i), .ap_start_o(w_ap_start),
        .ap_ready_i(ap_ready_i), .ap_done_i(ap_done_i), .ap_idle_i(ap_idle_i),
        .out_valid_i(out_valid_i), .out_ready_i(out_ready_i), .busy_o(w_busy),
        .done_o(w_done), .issued_o(w_issued), .finished_o(w_finished), .err_o(w_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_idle();
        ap_ready_i  = 1'b0;
        ap_done_i   = 1'b0;
        out_valid_i = 1'b0;
        out_ready_i = 1'b0;
        clear_i     = 1'b0;
        start_i     = 1'b0;
    endtask

    task automatic start_job(input int n, input int b);
        n_iter_i = 16'(n);
        beats_i  = 16'(b);
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        chk("rst_ap_start", ap_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_issued", issued_o, 0);
        chk("rst_finished", finished_o, 0);
        chk("rst_err", err_o, 0);

        // 1: 4 iterations x 16 beats, ready every cycle, done 10 cycles after each handshake
        st_cnt = 0; dn_cnt = 0; dn_at = 0; nbeat = 0; last_beat = 0;
        hs_cyc.delete();
        start_job(4, 16);
        for (int c = 1; c <= 120; c++) begin
            if (ap_start_o) begin
                st_cnt++;
                hs_cyc.push_back(c);
            end
            if (done_o) begin
                dn_cnt++;
                dn_at = c;
            end
            ap_ready_i = 1'b1;
            ap_done_i  = 1'b0;
            foreach (hs_cyc[k]) if (hs_cyc[k] + 10 == c) ap_done_i = 1'b1;
            out_valid_i = (c >= 11) && (nbeat < 64);
            out_ready_i = out_valid_i;
            if (out_valid_i) begin
                nbeat++;
                last_beat = c;
            end
            tick();
        end
        drive_idle();
        chk("t1_start_cycles", st_cnt, 4);
        chk("t1_done_count", dn_cnt, 1);
        chk("t1_done_after_last_beat", dn_at, last_beat + 1);
        chk("t1_done_cycle", dn_at, 75);
        chk("t1_issued", issued_o, 4);
        chk("t1_finished", finished_o, 4);
        chk("t1_err", err_o, 0);
        chk("t1_busy", busy_o, 0);

        // 2: zero iterations completes immediately without starting the kernel
        start_job(0, 5);
        chk("t2_done", done_o, 1);
        chk("t2_ap_start", ap_start_o, 0);
        chk("t2_busy", busy_o, 0);
        chk("t2_issued_cleared", issued_o, 0);
        tick();
        chk("t2_done_one_cycle", done_o, 0);
        chk("t2_ap_start_after", ap_start_o, 0);

        // 3: coincident ready+done, output stalled 50 cycles after the last done
        dn_cnt = 0; dn_at = 0;
        start_job(2, 4);
        for (int c = 1; c <= 80; c++) begin
            if (done_o) begin
                dn_cnt++;
                dn_at = c;
            end
            if (c == 6) begin
                chk("t3_issued_coincident", issued_o, 2);
                chk("t3_finished_coincident", finished_o, 1);
                chk("t3_ap_start_dropped", ap_start_o, 0);
            end
            if (c == 40) begin
                chk("t3_busy_stalled", busy_o, 1);
                chk("t3_no_early_done", dn_cnt, 0);
                chk("t3_finished_all", finished_o, 2);
            end
            ap_ready_i  = (c == 1) || (c == 5);
            ap_done_i   = (c == 5) || (c == 10);
            out_valid_i = (c >= 6 && c <= 9) || (c >= 11 && c <= 64);
            out_ready_i = (c >= 6 && c <= 9) || (c >= 61 && c <= 64);
            tick();
        end
        drive_idle();
        chk("t3_done_count", dn_cnt, 1);
        chk("t3_done_cycle", dn_at, 65);

        // 4a: extra ap_done after all finished; start while busy ignored; clear drops err
        start_job(1, 2);
        ap_ready_i = 1'b1; tick();
        ap_ready_i = 1'b0; ap_done_i = 1'b1; tick();
        ap_done_i = 1'b0; out_valid_i = 1'b1; out_ready_i = 1'b1; tick();
        out_valid_i = 1'b0; out_ready_i = 1'b0;
        chk("t4a_err_before", err_o, 0);
        ap_done_i = 1'b1; tick();
        ap_done_i = 1'b0;
        chk("t4a_err_set", err_o, 1);
        chk("t4a_busy", busy_o, 1);
        n_iter_i = 16'd7; start_i = 1'b1; tick();
        start_i = 1'b0;
        chk("t4a_err_sticky", err_o, 1);
        chk("t4a_start_ignored_issued", issued_o, 1);
        chk("t4a_start_ignored_ap_start", ap_start_o, 0);
        do_clear();
        chk("t4a_err_cleared", err_o, 0);
        chk("t4a_busy_cleared", busy_o, 0);
        chk("t4a_finished_cleared", finished_o, 0);

        // 4b: 9th beat with total=8 arrives in the DONE cycle; next start clears err
        start_job(2, 4);
        for (int c = 1; c <= 11; c++) begin
            if (c == 11) begin
                chk("t4b_done", done_o, 1);
                chk("t4b_err_before", err_o, 0);
            end
            ap_ready_i  = (c <= 2);
            ap_done_i   = (c == 5) || (c == 10);
            out_valid_i = (c >= 3);
            out_ready_i = (c >= 3);
            tick();
        end
        drive_idle();
        chk("t4b_err_set", err_o, 1);
        chk("t4b_busy", busy_o, 0);
        tick();
        tick();
        chk("t4b_err_sticky_idle", err_o, 1);
        start_job(0, 3);
        chk("t4b_err_cleared_by_start", err_o, 0);
        chk("t4b_done_zero_job", done_o, 1);
        tick();

        // 5: kernel not idle at start flags err; clear+start in ISSUE returns to IDLE
        ap_idle_i = 1'b0;
        start_job(3, 1);
        ap_idle_i = 1'b1;
        chk("t5_not_idle_err", err_o, 1);
        chk("t5_ap_start", ap_start_o, 1);
        ap_ready_i = 1'b1; tick();
        ap_ready_i = 1'b0;
        chk("t5_issued_one", issued_o, 1);
        clear_i = 1'b1; start_i = 1'b1; n_iter_i = 16'd5; tick();
        clear_i = 1'b0; start_i = 1'b0;
        chk("t5_ap_start_cleared", ap_start_o, 0);
        chk("t5_busy_cleared", busy_o, 0);
        chk("t5_issued_cleared", issued_o, 0);
        chk("t5_finished_cleared", finished_o, 0);
        chk("t5_err_cleared", err_o, 0);
        chk("t5_no_done", done_o, 0);
        tick();
        chk("t5_still_idle", ap_start_o, 0);
        chk("t5_no_done_later", done_o, 0);

        // 6: kernel never finishes; 4-bit watchdog expires after 15 idle cycles in WAIT
        dn_cnt = 0; dn_at = 0; err_at = 0;
        start_job(1, 1);
        for (int c = 1; c <= 40; c++) begin
            if (w_done) begin
                dn_cnt++;
                dn_at = c;
            end
            if (w_err && err_at == 0) err_at = c;
            ap_ready_i = (c == 1);
            tick();
        end
        drive_idle();
        chk("t6_err_cycle", err_at, 17);
        chk("t6_done_count", dn_cnt, 1);
        chk("t6_done_cycle", dn_at, 17);
        chk("t6_err_sticky", w_err, 1);
        chk("t6_busy_released", w_busy, 0);
        chk("t6_issued", w_issued, 1);
        chk("t6_finished", w_finished, 0);
        chk("t6_wide_wdog_still_busy", busy_o, 1);
        chk("t6_wide_wdog_no_err", err_o, 0);
        do_clear();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
